// File: rtl/xosera_pkg.sv
// Shared sprite constants, FSM state type and word-order helper for the sprite fetch path.
package xosera_pkg;

  localparam int SPRITE_W      = 32;
  localparam int SPRITE_H      = 32;
  localparam int SPRITE_BPP    = 4;
  localparam int SPRITE_ADDR_W = 8;
  localparam int WORD_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    ARMED,
    ACTIVE,
    DONE
  } spr_state_t;

  // A mirrored line walks the eight words of a row backwards (7 - k == ~k).
  function automatic logic [2:0] word_sel(input logic [2:0] k, input logic flip);
    return flip ? ~k : k;
  endfunction

endpackage

// File: rtl/sprite_shift.sv
// Sprite hold/shift register and nibble selection.
// Mirror logic only exists when SPRITE_HFLIP_EN is defined.
module sprite_shift
  import xosera_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  hold_ld,
  input  logic                  arm_ld,
  input  logic                  word_ld,
  input  logic                  shift_en,
  input  logic                  flip,
  input  logic [WORD_W-1:0]     data,
  output logic [SPRITE_BPP-1:0] pixel
);

  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      hold_q  <= '0;
      shift_q <= '0;
    end else begin
      if (hold_ld) hold_q <= data;
      if (arm_ld)
        shift_q <= hold_q;
      else if (word_ld)
        shift_q <= data;
      else if (shift_en)
`ifdef SPRITE_HFLIP_EN
        shift_q <= flip ? (shift_q >> SPRITE_BPP) : (shift_q << SPRITE_BPP);
`else
        shift_q <= shift_q << SPRITE_BPP;
`endif
    end
  end

`ifdef SPRITE_HFLIP_EN
  assign pixel = flip ? shift_q[SPRITE_BPP-1:0] : shift_q[WORD_W-1 -: SPRITE_BPP];
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign pixel = shift_q[WORD_W-1 -: SPRITE_BPP];
`endif

endmodule

// File: rtl/sprite_fetch.sv
// Per-scanline sprite fetch: preloads word 0, then streams 7 more words from BRAM
// just in time for the shifter. Horizontal mirror is built only with SPRITE_HFLIP_EN.
module sprite_fetch
  import xosera_pkg::*;
#(
  parameter int SPR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     line_start_i,
  input  logic [10:0]              h_count_i,
  input  logic [10:0]              v_count_i,
  input  logic                     sprite_en_i,
  input  logic [10:0]              sprite_x_i,
  input  logic [10:0]              sprite_y_i,
  input  logic                     hflip_i,
  output logic                     spr_rd_en_o,
  output logic [SPRITE_ADDR_W-1:0] spr_rd_addr_o,
  input  logic [WORD_W-1:0]        spr_rd_data_i,
  output logic [SPRITE_BPP-1:0]    pixel_o,
  output logic                     pixel_vis_o
);

  localparam logic [4:0] LAST_PIX = 5'(SPR_W - 1);

  spr_state_t state, state_nx;
  logic                     pre_wait, pre_wait_nx;
  logic [4:0]               pix_cnt, pix_cnt_nx;
  logic [4:0]               row_q, row_nx;
  logic [10:0]              x_q, x_nx;
  logic                     rd_en_nx;
  logic [SPRITE_ADDR_W-1:0] rd_addr_nx;
  logic [10:0]              row_calc;
  logic                     flip_q, flip_ls;
  logic                     hold_ld, arm_ld, word_ld, shift_en;
  logic [SPRITE_BPP-1:0]    nib;

  assign row_calc = v_count_i - sprite_y_i;

`ifdef SPRITE_HFLIP_EN
  logic flip_r;
  always_ff @(posedge clk) begin
    if (reset_i)           flip_r <= 1'b0;
    else if (line_start_i) flip_r <= hflip_i;
  end
  assign flip_q  = flip_r;
  assign flip_ls = hflip_i;
`else
  logic unused_hflip;
  assign unused_hflip = hflip_i;
  assign flip_q  = 1'b0;
  assign flip_ls = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state         <= IDLE;
      pre_wait      <= 1'b0;
      pix_cnt       <= '0;
      row_q         <= '0;
      x_q           <= '0;
      spr_rd_en_o   <= 1'b0;
      spr_rd_addr_o <= '0;
    end else begin
      state         <= state_nx;
      pre_wait      <= pre_wait_nx;
      pix_cnt       <= pix_cnt_nx;
      row_q         <= row_nx;
      x_q           <= x_nx;
      spr_rd_en_o   <= rd_en_nx;
      spr_rd_addr_o <= rd_addr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pre_wait_nx = 1'b0;
    pix_cnt_nx  = pix_cnt;
    row_nx      = row_q;
    x_nx        = x_q;
    rd_en_nx    = 1'b0;
    rd_addr_nx  = spr_rd_addr_o;
    hold_ld     = 1'b0;
    arm_ld      = 1'b0;
    word_ld     = 1'b0;
    shift_en    = 1'b0;
    if (line_start_i) begin
      x_nx   = sprite_x_i;
      row_nx = row_calc[4:0];
      if (sprite_en_i && (row_calc < 11'(SPRITE_H))) begin
        state_nx    = PRELOAD;
        pre_wait_nx = 1'b1;
        rd_en_nx    = 1'b1;
        rd_addr_nx  = {row_calc[4:0], word_sel(3'd0, flip_ls)};
      end else begin
        state_nx = IDLE;
      end
    end else begin
      case (state)
        // First PRELOAD cycle carries the read; data arrives in the second.
        PRELOAD: if (!pre_wait) begin
          hold_ld  = 1'b1;
          state_nx = ARMED;
        end
        ARMED: if (h_count_i == x_q) begin
          arm_ld     = 1'b1;
          pix_cnt_nx = '0;
          state_nx   = ACTIVE;
        end
        ACTIVE: begin
          shift_en   = 1'b1;
          pix_cnt_nx = pix_cnt + 5'd1;
          // Request word k two pixels ahead so it lands exactly at the reload.
          if (pix_cnt[1:0] == 2'd1 && pix_cnt < LAST_PIX - 5'd2) begin
            rd_en_nx   = 1'b1;
            rd_addr_nx = {row_q, word_sel(pix_cnt[4:2] + 3'd1, flip_q)};
          end
          if (pix_cnt[1:0] == 2'd3) begin
            shift_en = 1'b0;
            if (pix_cnt == LAST_PIX) state_nx = DONE;
            else                     word_ld  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sprite_shift u_shift (
    .clk      (clk),
    .reset_i  (reset_i),
    .hold_ld  (hold_ld),
    .arm_ld   (arm_ld),
    .word_ld  (word_ld),
    .shift_en (shift_en),
    .flip     (flip_q),
    .data     (spr_rd_data_i),
    .pixel    (nib)
  );

  assign pixel_o     = (state == ACTIVE) ? nib : '0;
  assign pixel_vis_o = (state == ACTIVE) && (nib != '0);

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a one-cycle-latency BRAM model (word n = n*0x1111).
module tb_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        line_start_i;
  logic [10:0] h_count_i, v_count_i, sprite_x_i, sprite_y_i;
  logic        sprite_en_i, hflip_i;
  logic        spr_rd_en_o;
  logic [7:0]  spr_rd_addr_o;
  logic [15:0] spr_rd_data_i;
  logic [3:0]  pixel_o;
  logic        pixel_vis_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];
  logic [3:0]  pix_at [2048];
  bit          vis_at [2048];
  int          rd_h [16];
  int          rd_a [16];
  int          rd_n;

  sprite_fetch #(.SPR_W(32)) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .line_start_i  (line_start_i),
    .h_count_i     (h_count_i),
    .v_count_i     (v_count_i),
    .sprite_en_i   (sprite_en_i),
    .sprite_x_i    (sprite_x_i),
    .sprite_y_i    (sprite_y_i),
    .hflip_i       (hflip_i),
    .spr_rd_en_o   (spr_rd_en_o),
    .spr_rd_addr_o (spr_rd_addr_o),
    .spr_rd_data_i (spr_rd_data_i),
    .pixel_o       (pixel_o),
    .pixel_vis_o   (pixel_vis_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (spr_rd_en_o) spr_rd_data_i <= mem[spr_rd_addr_o];

  task automatic fill_mem();
    for (int n = 0; n < 256; n++) mem[n] = 16'((n * 32'h1111) & 32'hFFFF);
  endtask

  // Drives one scanline fragment starting with line_start_i and logs outputs per h.
  task automatic do_line(input int v, input int x, input int y, input bit en, input bit flip,
                         input int ls_h, input int ncyc, input int rst_h, input int ls2_h);
    int h;
    rd_n = 0;
    for (int i = 0; i < 2048; i++) begin
      pix_at[i] = 4'h0;
      vis_at[i] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      h = (ls_h + c) % 2048;
      h_count_i    = 11'(h);
      v_count_i    = 11'(v);
      sprite_x_i   = 11'(x);
      sprite_y_i   = 11'(y);
      sprite_en_i  = en;
      hflip_i      = flip;
      line_start_i = (c == 0) || (h == ls2_h);
      reset_i      = (h == rst_h);
      #1;
      pix_at[h] = pixel_o;
      vis_at[h] = pixel_vis_o;
      if (spr_rd_en_o) begin
        if (rd_n < 16) begin
          rd_h[rd_n] = h;
          rd_a[rd_n] = int'(spr_rd_addr_o);
        end
        rd_n++;
      end
      @(posedge clk); #1;
    end
    line_start_i = 1'b0;
    reset_i      = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (spr_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", spr_rd_en_o); end
    checks++; if (spr_rd_addr_o !== 8'h00) begin errors++; $display("FAIL reset_rd_addr got=%h exp=00", spr_rd_addr_o); end
    checks++; if (pixel_o !== 4'h0) begin errors++; $display("FAIL reset_pixel got=%h exp=0", pixel_o); end
    checks++; if (pixel_vis_o !== 1'b0) begin errors++; $display("FAIL reset_vis got=%b exp=0", pixel_vis_o); end
    reset_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Row 1 -> words 8..15 = 0x8888..0xFFFF.
  task automatic test_main();
    do_line(51, 100, 50, 1'b1, 1'b0, 90, 50, -1, -1);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL main_read_count got=%0d exp=8", rd_n); end
    checks++; if (rd_h[0] !== 91) begin errors++; $display("FAIL main_preload_h got=%0d exp=91", rd_h[0]); end
    for (int k = 0; k < 8 && k < rd_n; k++) begin
      checks++;
      if (rd_a[k] !== 8 + k) begin errors++; $display("FAIL main_rd_addr k=%0d got=%h exp=%h", k, rd_a[k], 8 + k); end
      if (k > 0) begin
        checks++;
        if (rd_h[k] !== 100 + 4*k - 1) begin errors++; $display("FAIL main_rd_h k=%0d got=%0d exp=%0d", k, rd_h[k], 100 + 4*k - 1); end
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (pix_at[101+i] !== 4'(8 + i/4) || vis_at[101+i] !== 1'b1) begin
        errors++; $display("FAIL main_pixel i=%0d got=%h/%b exp=%h/1", i, pix_at[101+i], vis_at[101+i], 8 + i/4);
      end
    end
    checks++; if (vis_at[100] !== 1'b0 || vis_at[133] !== 1'b0) begin errors++; $display("FAIL main_edges got=%b,%b exp=0,0", vis_at[100], vis_at[133]); end
  endtask

  // Row 3 -> addresses 0x18..0x1F, pixels taken from (addr*0x1111)[15:0].
  task automatic test_row3();
    int w, e;
    do_line(53, 100, 50, 1'b1, 1'b0, 90, 50, -1, -1);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL row3_read_count got=%0d exp=8", rd_n); end
    for (int k = 0; k < 8 && k < rd_n; k++) begin
      checks++;
      if (rd_a[k] !== 8'h18 + k) begin errors++; $display("FAIL row3_rd_addr k=%0d got=%h exp=%h", k, rd_a[k], 8'h18 + k); end
    end
    for (int i = 0; i < 32; i++) begin
      w = ((24 + i/4) * 32'h1111) & 32'hFFFF;
      e = (w >> (4 * (3 - i%4))) & 15;
      checks++;
      if (pix_at[101+i] !== 4'(e)) begin errors++; $display("FAIL row3_pixel i=%0d got=%h exp=%h", i, pix_at[101+i], e); end
    end
  endtask

  task automatic test_out_of_range();
    int vs [3] = '{49, 82, 51};
    bit ens [3] = '{1'b1, 1'b1, 1'b0};
    int vc;
    for (int t = 0; t < 3; t++) begin
      do_line(vs[t], 100, 50, ens[t], 1'b0, 90, 50, -1, -1);
      vc = 0;
      for (int h = 90; h < 140; h++) if (vis_at[h]) vc++;
      checks++; if (rd_n !== 0) begin errors++; $display("FAIL oor_reads case=%0d got=%0d exp=0", t, rd_n); end
      checks++; if (vc !== 0) begin errors++; $display("FAIL oor_vis case=%0d got=%0d exp=0", t, vc); end
    end
  endtask

  task automatic test_transparent();
    bit ev [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] ep [4] = '{4'h0, 4'hF, 4'h0, 4'hF};
    mem[0] = 16'h0F0F;
    do_line(50, 0, 50, 1'b1, 1'b0, 2044, 44, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vis_at[1+i] !== ev[i] || pix_at[1+i] !== ep[i]) begin
        errors++; $display("FAIL transp h=%0d got=%h/%b exp=%h/%b", 1+i, pix_at[1+i], vis_at[1+i], ep[i], ev[i]);
      end
    end
    fill_mem();
  endtask

  task automatic test_reset_mid_line();
    int vc;
    do_line(51, 100, 50, 1'b1, 1'b0, 90, 50, 110, -1);
    vc = 0;
    for (int h = 111; h < 140; h++) if (vis_at[h] || pix_at[h] != 4'h0) vc++;
    checks++; if (rd_n !== 3) begin errors++; $display("FAIL rstmid_reads got=%0d exp=3", rd_n); end
    checks++; if (pix_at[110] !== 4'hA) begin errors++; $display("FAIL rstmid_before got=%h exp=a", pix_at[110]); end
    checks++; if (vc !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d exp=0", vc); end
    do_line(51, 100, 50, 1'b1, 1'b0, 90, 50, -1, -1);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL rstmid_resume_reads got=%0d exp=8", rd_n); end
    checks++; if (pix_at[105] !== 4'h9 || pix_at[132] !== 4'hF) begin
      errors++; $display("FAIL rstmid_resume_pix got=%h,%h exp=9,f", pix_at[105], pix_at[132]);
    end
  endtask

  task automatic test_restart();
    int vc;
    do_line(51, 100, 50, 1'b1, 1'b0, 90, 50, -1, 105);
    vc = 0;
    for (int h = 106; h < 140; h++) if (vis_at[h]) vc++;
    checks++; if (rd_n !== 3) begin errors++; $display("FAIL restart_reads got=%0d exp=3", rd_n); end
    checks++; if (rd_n >= 3 && (rd_h[2] !== 106 || rd_a[2] !== 8)) begin
      errors++; $display("FAIL restart_preload got=h%0d/a%h exp=h106/a08", rd_h[2], rd_a[2]);
    end
    checks++; if (vc !== 0) begin errors++; $display("FAIL restart_vis got=%0d exp=0", vc); end
  endtask

`ifdef SPRITE_HFLIP_EN
  task automatic test_hflip();
    logic [15:0] pat [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [3:0]  ep [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
    for (int k = 0; k < 8; k++) mem[k] = pat[k%4];
    do_line(50, 100, 50, 1'b1, 1'b1, 90, 50, -1, -1);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL hflip_reads got=%0d exp=8", rd_n); end
    checks++; if (rd_a[0] !== 7 || rd_a[1] !== 6) begin errors++; $display("FAIL hflip_order got=%h,%h exp=07,06", rd_a[0], rd_a[1]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pix_at[101+i] !== ep[i]) begin errors++; $display("FAIL hflip_pixel i=%0d got=%h exp=%h", i, pix_at[101+i], ep[i]); end
    end
    fill_mem();
  endtask
`endif

  initial begin
    reset_i = 1'b1; line_start_i = 1'b0; h_count_i = '0; v_count_i = '0;
    sprite_en_i = 1'b0; sprite_x_i = '0; sprite_y_i = '0; hflip_i = 1'b0;
    fill_mem();
    @(posedge clk); #1;
    test_reset();
    test_main();
    test_row3();
    test_out_of_range();
    test_transparent();
    test_reset_mid_line();
    test_restart();
`ifdef SPRITE_HFLIP_EN
    test_hflip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
